// File: rtl/mem_stage_rsp_pkg.sv
// Shared definitions for the MEM stage with split request/response memory:
// load opcode encoding and the bus width overheads around DATA_W.
package mem_stage_rsp_pkg;

  localparam logic [3:0] LD_FULL = 4'd0;
  localparam logic [3:0] LD_B    = 4'd1;
  localparam logic [3:0] LD_BU   = 4'd2;
  localparam logic [3:0] LD_H    = 4'd3;
  localparam logic [3:0] LD_HU   = 4'd4;
  localparam logic [3:0] LD_W    = 4'd5;
  localparam logic [3:0] LD_WU   = 4'd6;

  // Control/pc bits carried next to the DATA_W-wide value on each bus
  localparam int ES_BUS_EXTRA = 44;
  localparam int MS_BUS_EXTRA = 38;

endpackage

// File: rtl/mem_stage_rsp_load_align.sv
// Combinational load alignment: picks the addressed byte/half/word lane out of
// a full-width memory word, moves it to bit 0 and sign/zero-extends it.
module load_align
  import mem_stage_rsp_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [3:0]        ld_op,
  input  logic [OFF_W-1:0]  offset,
  input  logic [DATA_W-1:0] raw,
  output logic [DATA_W-1:0] result
);

  // Half/word lanes are taken from the offset rounded down to the access size
  localparam logic [OFF_W-1:0] HALF_MASK = ~OFF_W'(1);
  localparam logic [OFF_W-1:0] WORD_MASK = ~OFF_W'(3);

  logic [OFF_W-1:0]   off_h;
  logic [OFF_W-1:0]   off_w;
  logic [7:0]         lane_b;
  logic [15:0]        lane_h;
  logic [31:0]        lane_w;
  logic signed [7:0]  lane_b_s;
  logic signed [15:0] lane_h_s;
  logic signed [31:0] lane_w_s;

  assign off_h    = offset & HALF_MASK;
  assign off_w    = offset & WORD_MASK;
  assign lane_b   = 8'(raw >> {offset, 3'b000});
  assign lane_h   = 16'(raw >> {off_h, 3'b000});
  assign lane_w   = 32'(raw >> {off_w, 3'b000});
  assign lane_b_s = lane_b;
  assign lane_h_s = lane_h;
  assign lane_w_s = lane_w;

  // Size casts of signed lanes sign-extend, of unsigned lanes zero-extend;
  // at DATA_W=32 the word lane is the whole word, so ld.w/ld.wu act as full width
  always_comb begin
    result = raw;
    case (ld_op)
      LD_B:    result = DATA_W'(lane_b_s);
      LD_BU:   result = DATA_W'(lane_b);
      LD_H:    result = DATA_W'(lane_h_s);
      LD_HU:   result = DATA_W'(lane_h);
      LD_W:    result = DATA_W'(lane_w_s);
      LD_WU:   result = DATA_W'(lane_w);
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/mem_stage_rsp.sv
// MEM pipeline stage for a data memory with a split request/response
// handshake. Holds one instruction, stalls loads until their response,
// buffers a response that arrives while WB is stalled, and counts responses
// that belong to flushed loads so they are dropped instead of consumed.
module mem_stage_rsp
  import mem_stage_rsp_pkg::*;
#(
  parameter int DATA_W          = 32,
  parameter int ES_TO_MS_BUS_WD = DATA_W + ES_BUS_EXTRA,
  parameter int MS_TO_WS_BUS_WD = DATA_W + MS_BUS_EXTRA
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [4:0]                 ms_to_ds_dest,
  output logic [DATA_W-1:0]          ms_to_ds_value,
  output logic                       ms_to_ds_block,
  input  logic                       flush,
  input  logic                       data_sram_data_ok,
  input  logic [DATA_W-1:0]          data_sram_rdata
);

  localparam int OFF_W = $clog2(DATA_W / 8);

  logic                       ms_valid;
  logic                       buf_valid;
  logic [1:0]                 cancel_cnt;
  logic [ES_TO_MS_BUS_WD-1:0] ms_bus_p1;
  logic [DATA_W-1:0]          buf_data_p1;

  logic [3:0]        ld_op;
  logic              req_issued;
  logic              res_from_mem;
  logic              gr_we;
  logic [4:0]        dest;
  logic [DATA_W-1:0] alu_result;
  logic [31:0]       pc;

  logic              wait_load;
  logic              rsp_ok;
  logic              ms_ready_go;
  logic              ms_leave;
  logic              buf_cap;
  logic              cancel_inc;
  logic              cancel_dec;
  logic [DATA_W-1:0] rsp_aligned;
  logic [DATA_W-1:0] mem_result;
  logic [DATA_W-1:0] final_result;

  // Saturating up/down step for the count of responses still owed to flushed loads
  function automatic logic [1:0] cancel_step(logic [1:0] cnt, logic inc, logic dec);
    logic [1:0] nxt;
    nxt = cnt;
    if (inc && !dec && cnt != 2'd3)
      nxt = cnt + 2'd1;
    else if (dec && !inc)
      nxt = cnt - 2'd1;
    return nxt;
  endfunction

  assign {ld_op, req_issued, res_from_mem, gr_we, dest, alu_result, pc} = ms_bus_p1;

  assign wait_load   = res_from_mem && req_issued;
  // A response only belongs to the resident load once no cancelled ones are ahead of it
  assign rsp_ok      = data_sram_data_ok && (cancel_cnt == 2'd0);
  assign ms_ready_go = !ms_valid || !wait_load || buf_valid || rsp_ok;
  assign ms_allowin  = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go && !flush;
  assign ms_leave    = ms_to_ws_valid && ws_allowin;

  assign buf_cap     = ms_valid && wait_load && !buf_valid && rsp_ok && !ws_allowin;
  assign cancel_inc  = flush && ms_valid && wait_load && !buf_valid && !rsp_ok;
  assign cancel_dec  = data_sram_data_ok && (cancel_cnt != 2'd0);

  load_align #(
    .DATA_W (DATA_W),
    .OFF_W  (OFF_W)
  ) u_load_align (
    .ld_op  (ld_op),
    .offset (alu_result[OFF_W-1:0]),
    .raw    (data_sram_rdata),
    .result (rsp_aligned)
  );

  assign mem_result     = buf_valid ? buf_data_p1 : rsp_aligned;
  assign final_result   = res_from_mem ? mem_result : alu_result;
  assign ms_to_ws_bus   = {gr_we, dest, final_result, pc};
  assign ms_to_ds_dest  = (ms_valid && gr_we) ? dest : 5'd0;
  assign ms_to_ds_value = final_result;
  assign ms_to_ds_block = ms_valid && wait_load && !buf_valid && !rsp_ok;

  // ---- EX -> MEM boundary ----

  // Occupancy of the stage; a flush wins over an instruction arriving the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ms_valid <= 1'b0;
    else if (flush)
      ms_valid <= 1'b0;
    else if (ms_allowin)
      ms_valid <= es_to_ms_valid;
  end

  // Instruction payload register, loaded on every EX->MEM handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ms_bus_p1 <= '0;
    else if (es_to_ms_valid && ms_allowin)
      ms_bus_p1 <= es_to_ms_bus;
  end

  // Response buffer flag: set when data arrives while WB stalls, cleared when the load leaves
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      buf_valid <= 1'b0;
    else if (flush || ms_leave)
      buf_valid <= 1'b0;
    else if (buf_cap)
      buf_valid <= 1'b1;
  end

  // Buffered aligned load data; only meaningful while buf_valid is set
  always_ff @(posedge clk) begin
    if (buf_cap)
      buf_data_p1 <= rsp_aligned;
  end

  // Number of in-flight responses that belong to flushed loads
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cancel_cnt <= 2'd0;
    else
      cancel_cnt <= cancel_step(cancel_cnt, cancel_inc, cancel_dec);
  end

endmodule

// File: tb/tb_mem_stage_rsp.sv
// Bench for mem_stage_rsp: in-order memory model with per-request latency,
// expected-instruction queue filled on EX->MEM handshakes and drained by a
// separate monitor on every WB handshake.
module tb_mem_stage_rsp;
  import mem_stage_rsp_pkg::*;

  localparam int DW   = 32;
  localparam int ESW  = DW + 44;
  localparam int MSW  = DW + 38;
  localparam int DW2  = 64;
  localparam int ESW2 = DW2 + 44;
  localparam int MSW2 = DW2 + 38;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance signals
  logic           ws_allowin = 1'b1;
  logic           ms_allowin;
  logic           es_to_ms_valid = 1'b0;
  logic [ESW-1:0] es_to_ms_bus = '0;
  logic           ms_to_ws_valid;
  logic [MSW-1:0] ms_to_ws_bus;
  logic [4:0]     ms_to_ds_dest;
  logic [DW-1:0]  ms_to_ds_value;
  logic           ms_to_ds_block;
  logic           flush = 1'b0;
  logic           data_sram_data_ok = 1'b0;
  logic [DW-1:0]  data_sram_rdata = '0;

  // 64-bit instance signals
  logic            ws_allowin_w = 1'b1;
  logic            ms_allowin_w;
  logic            es_to_ms_valid_w = 1'b0;
  logic [ESW2-1:0] es_to_ms_bus_w = '0;
  logic            ms_to_ws_valid_w;
  logic [MSW2-1:0] ms_to_ws_bus_w;
  logic [4:0]      ms_to_ds_dest_w;
  logic [DW2-1:0]  ms_to_ds_value_w;
  logic            ms_to_ds_block_w;
  logic            flush_w = 1'b0;
  logic            data_ok_w = 1'b0;
  logic [DW2-1:0]  rdata_w = '0;

  mem_stage_rsp #(.DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .ws_allowin(ws_allowin), .ms_allowin(ms_allowin),
    .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
    .ms_to_ds_dest(ms_to_ds_dest), .ms_to_ds_value(ms_to_ds_value),
    .ms_to_ds_block(ms_to_ds_block), .flush(flush),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata)
  );

  mem_stage_rsp #(.DATA_W(DW2)) dut64 (
    .clk(clk), .reset(reset), .ws_allowin(ws_allowin_w), .ms_allowin(ms_allowin_w),
    .es_to_ms_valid(es_to_ms_valid_w), .es_to_ms_bus(es_to_ms_bus_w),
    .ms_to_ws_valid(ms_to_ws_valid_w), .ms_to_ws_bus(ms_to_ws_bus_w),
    .ms_to_ds_dest(ms_to_ds_dest_w), .ms_to_ds_value(ms_to_ds_value_w),
    .ms_to_ds_block(ms_to_ds_block_w), .flush(flush_w),
    .data_sram_data_ok(data_ok_w), .data_sram_rdata(rdata_w)
  );

  typedef struct {
    logic [31:0] data;
    int          ready;
    bit          live;
  } rsp_t;

  typedef struct {
    bit          is_load;
    bit          gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } ins_t;

  rsp_t mem_q[$];   // responses the memory still owes, oldest first
  ins_t exp_q[$];   // instruction currently held in MEM (0 or 1 entries, 2 transiently)

  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  bit   accepted;
  int   block_cnt;
  ins_t pend;
  logic [31:0] pend_data;
  int   pend_delay;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
  endtask

  // Reference alignment from the addressing rules, using plain integer arithmetic
  function automatic logic [31:0] ref32(logic [3:0] op, logic [31:0] addr, logic [31:0] rd);
    longint v;
    int     byte_idx;
    byte_idx = int'(addr % 4);
    case (op)
      4'd1, 4'd2: begin
        v = longint'((rd >> (8 * byte_idx)) & 32'hFF);
        if (op == 4'd1 && v >= 128) v = v - 256;
      end
      4'd3, 4'd4: begin
        v = longint'((rd >> (16 * (byte_idx / 2))) & 32'hFFFF);
        if (op == 4'd3 && v >= 32768) v = v - 65536;
      end
      default: v = longint'(rd);
    endcase
    return v[31:0];
  endfunction

  // Monitor: compares MEM outputs against the queued model every cycle
  always @(negedge clk) begin
    bit   live_wait, delivering, stalled, occ;
    ins_t e;
    if (!reset) begin
      live_wait = 1'b0;
      foreach (mem_q[i]) if (mem_q[i].live) live_wait = 1'b1;
      delivering = data_sram_data_ok && mem_q.size() > 0 && mem_q[0].live;
      occ = exp_q.size() > 0;
      if (occ) e = exp_q[0];
      stalled = occ && e.is_load && live_wait && !delivering;
      check("out_valid", 64'(ms_to_ws_valid), 64'(occ && !stalled && !flush));
      check("ds_block", 64'(ms_to_ds_block), 64'(stalled));
      check("ds_dest", 64'(ms_to_ds_dest), 64'((occ && e.gr_we) ? e.dest : 5'd0));
      if (ms_to_ws_valid && ws_allowin && occ) begin
        void'(exp_q.pop_front());
        check("out_bus", 64'(ms_to_ws_bus), 64'({e.gr_we, e.dest, e.result, e.pc}));
        check("ds_value", 64'(ms_to_ds_value), 64'(e.result));
      end
    end
  end

  // One clock of stimulus; called just after a rising edge with EX/WB/flush inputs set
  task automatic tick();
    bit resp;
    resp = mem_q.size() > 0 && mem_q[0].ready <= cyc;
    data_sram_data_ok = resp;
    data_sram_rdata   = resp ? mem_q[0].data : $urandom;
    @(negedge clk);
    #1;
    if (ms_to_ds_block && !ms_allowin) block_cnt++;
    accepted = es_to_ms_valid && ms_allowin && !flush;
    if (resp) void'(mem_q.pop_front());
    if (flush) begin
      if (exp_q.size() > 0) void'(exp_q.pop_back());
      foreach (mem_q[i]) mem_q[i].live = 1'b0;
    end
    if (accepted) begin
      exp_q.push_back(pend);
      if (pend.is_load) mem_q.push_back('{data: pend_data, ready: cyc + 1 + pend_delay, live: 1'b1});
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_ins(bit ld, logic [3:0] op, logic [31:0] alu, logic [31:0] rd, int dly,
                         bit we, logic [4:0] dst, logic [31:0] pc);
    pend.is_load = ld;
    pend.gr_we   = we;
    pend.dest    = dst;
    pend.pc      = pc;
    pend.result  = ld ? ref32(op, alu, rd) : alu;
    pend_data    = rd;
    pend_delay   = dly;
    es_to_ms_bus   = {op, ld, ld, we, dst, alu, pc};
    es_to_ms_valid = 1'b1;
  endtask

  task automatic run_ins(bit ld, logic [3:0] op, logic [31:0] alu, logic [31:0] rd, int dly,
                         bit we, logic [4:0] dst, logic [31:0] pc);
    set_ins(ld, op, alu, rd, dly, we, dst, pc);
    accepted = 1'b0;
    for (int i = 0; i < 50 && !accepted; i++) tick();
    check("accept", 64'(accepted), 64'd1);
    es_to_ms_valid = 1'b0;
  endtask

  task automatic drain();
    es_to_ms_valid = 1'b0;
    flush = 1'b0;
    ws_allowin = 1'b1;
    for (int i = 0; i < 80 && (exp_q.size() > 0 || mem_q.size() > 0); i++) tick();
    check("drain", 64'(exp_q.size() + mem_q.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time %0t reached limit 1000000", $time);
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [3:0]  ops64 [4];
    logic [63:0] alu64 [4];
    logic [63:0] rd64  [4];
    logic [63:0] exp64 [4];

    // Reset state, checked before any clock edge
    #1 reset = 1'b1;
    #1;
    check("rst_out_valid", 64'(ms_to_ws_valid), 64'd0);
    check("rst_block", 64'(ms_to_ds_block), 64'd0);
    check("rst_dest", 64'(ms_to_ds_dest), 64'd0);
    check("rst_allowin", 64'(ms_allowin), 64'd1);
    check("rst_bus", 64'(ms_to_ws_bus), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // ld.b of the top byte, response in the first MEM cycle
    ws_allowin = 1'b1;
    run_ins(1'b1, LD_B, 32'h0000_1003, 32'h80FF_1234, 0, 1'b1, 5'd5, 32'h1c00_0000);
    drain();
    check("ldb_value", 64'(ref32(LD_B, 32'h1003, 32'h80FF_1234)), 64'h0000_0000_FFFF_FF80);

    // Half loads at offset 2, zero- and sign-extended
    run_ins(1'b1, LD_HU, 32'h0000_2002, 32'h8001_0000, 0, 1'b1, 5'd6, 32'h1c00_0004);
    run_ins(1'b1, LD_H,  32'h0000_2002, 32'h8001_0000, 0, 1'b1, 5'd7, 32'h1c00_0008);
    drain();

    // Response three cycles late: ID blocked and MEM closed for exactly three cycles
    block_cnt = 0;
    run_ins(1'b1, LD_FULL, 32'h0000_3000, 32'hCAFE_F00D, 3, 1'b1, 5'd8, 32'h1c00_000c);
    drain();
    check("late_block_cycles", 64'(block_cnt), 64'd3);

    // Response lands while WB is stalled for two more cycles; buffered value emitted later
    ws_allowin = 1'b0;
    run_ins(1'b1, LD_BU, 32'h0000_4001, 32'h1234_A5C3, 0, 1'b1, 5'd9, 32'h1c00_0010);
    tick(); tick(); tick();
    drain();

    // Flush while waiting; the cancelled 0xDEAD response must be dropped
    run_ins(1'b1, LD_FULL, 32'h0000_5000, 32'h0000_DEAD, 4, 1'b1, 5'd10, 32'h1c00_0014);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    run_ins(1'b1, LD_FULL, 32'h0000_5004, 32'h0000_1234, 1, 1'b1, 5'd11, 32'h1c00_0018);
    drain();

    // Asynchronous reset in the middle of a wait
    run_ins(1'b1, LD_FULL, 32'h0000_6000, 32'h7777_7777, 10, 1'b1, 5'd12, 32'h1c00_001c);
    tick();
    check("pre_rst_dest", 64'(ms_to_ds_dest), 64'd12);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(ms_to_ws_valid), 64'd0);
    check("mid_rst_block", 64'(ms_to_ds_block), 64'd0);
    check("mid_rst_dest", 64'(ms_to_ds_dest), 64'd0);
    check("mid_rst_allowin", 64'(ms_allowin), 64'd1);
    check("mid_rst_bus", 64'(ms_to_ws_bus), 64'd0);
    mem_q.delete();
    exp_q.delete();
    data_sram_data_ok = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    run_ins(1'b1, LD_H, 32'h0000_7000, 32'h0000_F00F, 2, 1'b1, 5'd13, 32'h1c00_0020);
    drain();

    // Randomised traffic against the queue model
    for (int n = 0; n < 3000; n++) begin
      ws_allowin = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 2) != 0) begin
        set_ins(mem_q.size() < 2 && $urandom_range(0, 1) == 1, 4'($urandom_range(0, 7)),
                $urandom, $urandom, $urandom_range(0, 4), 1'($urandom), 5'($urandom), $urandom);
      end else begin
        es_to_ms_valid = 1'b0;
      end
      tick();
    end
    drain();

    // DATA_W=64 word/half/byte lanes
    ops64[0] = LD_WU; alu64[0] = 64'h4; rd64[0] = 64'hF000_0001_0000_0000; exp64[0] = 64'h0000_0000_F000_0001;
    ops64[1] = LD_W;  alu64[1] = 64'h4; rd64[1] = 64'hF000_0001_0000_0000; exp64[1] = 64'hFFFF_FFFF_F000_0001;
    ops64[2] = LD_H;  alu64[2] = 64'h7; rd64[2] = 64'h8001_0000_0000_0000; exp64[2] = 64'hFFFF_FFFF_FFFF_8001;
    ops64[3] = LD_B;  alu64[3] = 64'h3; rd64[3] = 64'h0000_0000_8000_0000; exp64[3] = 64'hFFFF_FFFF_FFFF_FF80;
    for (int k = 0; k < 4; k++) begin
      es_to_ms_bus_w   = {ops64[k], 1'b1, 1'b1, 1'b1, 5'd3, alu64[k], 32'h1c00_0100};
      es_to_ms_valid_w = 1'b1;
      @(posedge clk);
      #1;
      es_to_ms_valid_w = 1'b0;
      data_ok_w = 1'b1;
      rdata_w   = rd64[k];
      #1;
      check("w64_valid", 64'(ms_to_ws_valid_w), 64'd1);
      check("w64_value", ms_to_ds_value_w, exp64[k]);
      @(posedge clk);
      #1;
      data_ok_w = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
